serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 100 ++++++++++
 tb/tb_serial_subtractor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, diff = a - b - bin, LSB first
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled only when idle or in the done cycle
//   a, b   minuend / subtrahend, bin borrow-in (latched on the start edge)
//   busy   high while an operation is in flight (RUN and DONE)
//   done   one-cycle pulse when diff/bout are updated
//   diff   a - b - bin modulo 2^WIDTH, bout unsigned borrow-out
//   ovf    signed overflow, present only when SERIAL_SUB_OVF_EN is defined
module serial_subtractor #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, res;
    logic [CNT_W-1:0] cnt;
    logic             br, d, br_n;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb, b_msb;
`endif
    assign d    = a_sr[0] ^ b_sr[0] ^ br;
    assign br_n = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    // RUN spends WIDTH cycles shifting bits and one more publishing the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= bin;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(WIDTH)) begin
                        state <= DONE;
                        diff  <= res;
                        bout  <= br;
                        done  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        ovf   <= (a_msb ^ b_msb) & (a_msb ^ res[WIDTH-1]);
`endif
                    end else begin
                        res  <= {d, res[WIDTH-1:1]};
                        a_sr <= a_sr >> 1;
                        b_sr <= b_sr >> 1;
                        br   <= br_n;
                        cnt  <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed self-checking bench for serial_subtractor
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       bin = 1'b0;
    logic       busy, done, bout;
    logic [7:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
    logic       held_ovf = 1'b0;
`endif
    int         checks = 0, errors = 0, edges = 0;
    logic [7:0] held_diff = '0;
    logic       held_bout = 1'b0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff),
`ifdef SERIAL_SUB_OVF_EN
        .ovf(ovf),
`endif
        .bout(bout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic launch(input logic [7:0] la, input logic [7:0] lb, input logic lbin);
        a = la;
        b = lb;
        bin = lbin;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        bin = 1'($urandom_range(0, 1));
        edges = 0;
    endtask

    task automatic wait_done(input logic [7:0] ea, input logic [7:0] eb, input logic ebin, input string name);
        int r, sr;
        logic [7:0] ed;
        logic eo;
        r  = int'(ea) - int'(eb) - int'(ebin);
        ed = 8'(r);
        eo = r < 0;
        sr = int'($signed(ea)) - int'($signed(eb)) - int'(ebin);
        for (int i = 0; i < 30 && done !== 1'b1; i++) begin
            checks++;
            if (busy !== 1'b1 || diff !== held_diff || bout !== held_bout) begin
                errors++;
                $display("FAIL %s hold: busy=%b diff=%h bout=%b, required busy=1 diff=%h bout=%b",
                         name, busy, diff, bout, held_diff, held_bout);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: done=%b, required 1", name, done);
        end
        checks++;
        if (edges !== 9) begin
            errors++;
            $display("FAIL %s latency: %0d edges, required 9", name, edges);
        end
        checks++;
        if (diff !== ed || bout !== eo || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s result: diff=%h bout=%b busy=%b, required diff=%h bout=%b busy=1",
                     name, diff, bout, busy, ed, eo);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf !== (sr < -128 || sr > 127)) begin
            errors++;
            $display("FAIL %s ovf: %b, required %b", name, ovf, sr < -128 || sr > 127);
        end
        held_ovf = sr < -128 || sr > 127;
`endif
        held_diff = ed;
        held_bout = eo;
    endtask

    task automatic check_idle(input string name);
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || diff !== held_diff || bout !== held_bout) begin
            errors++;
            $display("FAIL %s idle: done=%b busy=%b diff=%h bout=%b, required 0 0 %h %b",
                     name, done, busy, diff, bout, held_diff, held_bout);
        end
    endtask

    task automatic op(input logic [7:0] oa, input logic [7:0] ob, input logic obin, input string name);
        launch(oa, ob, obin);
        wait_done(oa, ob, obin, name);
        check_idle(name);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b diff=%h bout=%b, required all 0", busy, done, diff, bout);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset ovf: %b, required 0", ovf);
        end
`endif
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        op(8'h50, 8'h20, 1'b0, "d_50_20");
        op(8'h00, 8'h01, 1'b0, "d_00_01");
        op(8'hFF, 8'hFF, 1'b1, "d_ff_ff_1");
        op(8'h05, 8'h05, 1'b0, "d_05_05");
        op(8'h80, 8'h01, 1'b0, "d_80_01");
        op(8'h7F, 8'h01, 1'b0, "d_7f_01");
        op(8'h7F, 8'hFF, 1'b0, "d_7f_ff");
    endtask

    task automatic test_random();
        logic [7:0] ra, rb;
        logic rbin;
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rbin = 1'($urandom_range(0, 1));
            op(ra, rb, rbin, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        launch(8'h9C, 8'h21, 1'b1);
        wait_done(8'h9C, 8'h21, 1'b1, "b2b_first");
        launch(8'h10, 8'h03, 1'b0);
        wait_done(8'h10, 8'h03, 1'b0, "b2b_second");
        check_idle("b2b_second");
    endtask

    task automatic test_ignore_mid();
        int pulses = 0;
        launch(8'h3A, 8'h5C, 1'b0);
        tick();
        tick();
        tick();
        a = 8'hC3;
        b = 8'h11;
        bin = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(8'h3A, 8'h5C, 1'b0, "ignore_mid");
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_mid extra: %0d extra done pulses busy=%b, required 0 and 0", pulses, busy);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        launch(8'hE7, 8'h19, 1'b0);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b diff=%h bout=%b, required all 0", busy, done, diff, bout);
        end
        held_diff = '0;
        held_bout = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || diff !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid pulse: %0d done pulses diff=%h, required 0 and 00", pulses, diff);
        end
        op(8'h64, 8'h65, 1'b1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_mid();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
